ex_div: RTL
===========

# ex_div

Multi-cycle integer divider on the consuming side of the ID/EX pipeline register. Watches the decoded operation and operands presented to EX and executes DIV and DIVU as a 32-iteration radix-2 restoring division. Holds the front of the pipeline with a stall request while it iterates, then delivers quotient and remainder for the HI/LO write path. Other ALU operations pass through it untouched; it only produces stall and HI/LO results.

## Interface
- No parameters; widths come from the shared defines: `AluOpBus` 8 bits, `RegBus` 32 bits.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- ex_aluop  in  `AluOpBus`  decoded op from ID/EX.
- ex_reg1  in  `RegBus`  dividend.
- ex_reg2  in  `RegBus`  divisor.
- annul  in  1  flush: abandon any division in progress.
- stallreq  out  1  request to hold PC, IF/ID and ID/EX.
- whilo_o  out  1  HI/LO write enable, one-cycle pulse.
- hi_o  out  `RegBus`  remainder.
- lo_o  out  `RegBus`  quotient.

## Operation
- State machine states are DivFree, DivOn, DivByZero and DivEnd.
- **DivFree**
  - If ex_aluop is `EXE_DIV_OP` or `EXE_DIVU_OP` and annul=0, latch the operands.
  - Signed: latch absolute values and record both signs. Unsigned: latch raw values.
  - Divisor 0 goes to DivByZero; otherwise go to DivOn with cnt=0.
- **DivOn**, one iteration per cycle:
  - rem_next = {rem[30:0], dvd[31]}.
  - If rem_next ≥ dvs: subtract dvs and shift quotient bit 1 in; else shift 0 in.
  - Compare and subtract at 33 bits so the unsigned 0xFFFFFFFF case is correct.
  - After iteration 31 (cnt==31), go to DivEnd.
- **DivByZero**: one cycle, then DivEnd with lo=0xFFFFFFFF and hi=dividend (raw operand).
- **DivEnd**:
  - whilo_o=1 and stallreq=0; go to DivFree.
  - Signed fixup: negate the quotient if the operand signs differ; the remainder takes the sign of the dividend.
  - Overflow case 0x80000000 / 0xFFFFFFFF (signed) gives lo=0x80000000, hi=0 with no trap.
- **stallreq**, combinational:
  - 1 in DivFree when a div op is presented and annul=0.
  - 1 in DivOn and DivByZero.
  - 0 in DivEnd and otherwise.
- **annul** in any state except DivEnd: next state DivFree, no whilo pulse. If annul and a div op arrive together in DivFree, annul wins.
- **Non-div ops**: stay in DivFree with stallreq=0, whilo_o=0.

## Timing
- **Reset values**: state DivFree; stallreq=0, whilo_o=0, hi_o=0, lo_o=0; cnt and datapath registers 0.
- **Reset mid-division**: next cycle is DivFree with no result pulse.
- **Issue cycle N**: stallreq=1 at cycle N.
  - Iterations run in cycles N+1..N+32.
  - The result is valid in cycle N+33 (whilo_o=1, stallreq=0).
  - Stall is asserted for 33 cycles; the pipeline advances at the end of N+33.
- **Divide by zero**: stallreq is high in cycles N and N+1; the result arrives in N+2.
- **Outputs outside DivEnd**: hi_o and lo_o are registered and hold their last value; consumers qualify with whilo_o.
- **Back-to-back divisions**: because the same op is still presented during DivEnd, the FSM only re-arms from DivFree, so a second division starts the cycle after DivEnd.

## Structure
- Shared defines file gains:
  - state encodings DivFree=2'b00, DivByZero=2'b01, DivOn=2'b10, DivEnd=2'b11;
  - `EXE_DIV_OP`=8'b00011010 and `EXE_DIVU_OP`=8'b00011011, if not already present;
  - `DivResultReady`, `DivStart`.
- Single module, no sub-module. Estimated size is about 180 lines of RTL.
- The stall request is ORed into the existing pipeline control alongside other stall sources.

## Test plan
- DIVU 100 / 7: stallreq is high for exactly 33 cycles, then whilo_o pulses with lo=14, hi=2.
- DIV 0xFFFFFFF9 (−7) / 2: lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 7 / 0xFFFFFFFE: lo=0xFFFFFFFD, hi=1.
- DIVU 0xFFFFFFFF / 1: lo=0xFFFFFFFF, hi=0. DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- DIVU 5 / 0: stallreq is high for 2 cycles, then lo=0xFFFFFFFF, hi=5 with a single whilo_o pulse.
- Assert annul in DivOn iteration 10: next cycle is DivFree with stallreq=0 and no whilo_o. Repeat with rst: all outputs read 0 the following cycle.
- Two consecutive DIVU ops (100/7, then 9/3): two whilo_o pulses separated by 34 cycles; the second gives lo=3, hi=0.

Source files
------------

// File: rtl/ex_div_pkg.sv
// ============================================================================
// ex_div_pkg : shared widths, op codes and divider state encodings
// Revision  : 1.0
// ============================================================================
`default_nettype none

package ex_div_pkg;

  localparam int ALU_OP_W = 8;
  localparam int REG_W    = 32;

  localparam logic [ALU_OP_W-1:0] EXE_DIV_OP  = 8'b00011010;
  localparam logic [ALU_OP_W-1:0] EXE_DIVU_OP = 8'b00011011;

  localparam logic [1:0] DIV_FREE    = 2'b00;
  localparam logic [1:0] DIV_BY_ZERO = 2'b01;
  localparam logic [1:0] DIV_ON      = 2'b10;
  localparam logic [1:0] DIV_END     = 2'b11;

  localparam logic DIV_RESULT_READY = 1'b1;
  localparam logic DIV_START        = 1'b1;

  function automatic logic is_div_op(input logic [ALU_OP_W-1:0] op);
    return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ex_div_if.sv
// ============================================================================
// ex_div_if : EX-stage operand/op feed into the divider and its HI/LO results
// Revision  : 1.0
// ============================================================================
`default_nettype none

interface ex_div_if;

  logic [ex_div_pkg::ALU_OP_W-1:0] ex_aluop;
  logic [ex_div_pkg::REG_W-1:0]    ex_reg1;
  logic [ex_div_pkg::REG_W-1:0]    ex_reg2;
  logic                            annul;
  logic                            stallreq;
  logic                            whilo_o;
  logic [ex_div_pkg::REG_W-1:0]    hi_o;
  logic [ex_div_pkg::REG_W-1:0]    lo_o;

  modport master (
    output ex_aluop, ex_reg1, ex_reg2, annul,
    input  stallreq, whilo_o, hi_o, lo_o
  );

  modport slave (
    input  ex_aluop, ex_reg1, ex_reg2, annul,
    output stallreq, whilo_o, hi_o, lo_o
  );

endinterface

`default_nettype wire

// File: rtl/ex_div.sv
// ============================================================================
// ex_div : 32-iteration radix-2 restoring divider for DIV/DIVU with stall
// Revision  : 1.0
// ============================================================================
`default_nettype none

module ex_div
  import ex_div_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  ex_div_if.slave   bus
);

  logic [1:0]       state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [REG_W-1:0] dvd_q, dvd_d;
  logic [REG_W-1:0] dvs_q, dvs_d;
  logic [REG_W-1:0] rem_q, rem_d;
  logic [REG_W-1:0] raw_dvd_q, raw_dvd_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [REG_W-1:0] hi_q, hi_d;
  logic [REG_W-1:0] lo_q, lo_d;

  logic             start;
  logic             is_signed;
  logic [REG_W:0]   rem_shift;
  logic             fits;
  logic [REG_W-1:0] rem_new;
  logic [REG_W-1:0] quo_new;
  logic             stallreq;
  logic             whilo;

  assign start     = is_div_op(bus.ex_aluop) && !bus.annul;
  assign is_signed = (bus.ex_aluop == EXE_DIV_OP);

  // dvd_q doubles as the quotient: dividend bits shift out the top while
  // quotient bits shift in at the bottom. 33-bit compare covers rem >= 2^31.
  assign rem_shift = {rem_q, dvd_q[REG_W-1]};
  assign fits      = (rem_shift >= {1'b0, dvs_q});
  assign rem_new   = fits ? (rem_shift[REG_W-1:0] - dvs_q) : rem_shift[REG_W-1:0];
  assign quo_new   = {dvd_q[REG_W-2:0], fits};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= DIV_FREE;
      cnt_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      raw_dvd_q <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      raw_dvd_q <= raw_dvd_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DIV_FREE: begin
        if (start == DIV_START)
          state_d = (bus.ex_reg2 == '0) ? DIV_BY_ZERO : DIV_ON;
      end
      DIV_ON: begin
        if (bus.annul)
          state_d = DIV_FREE;
        else if (cnt_q == 5'd31)
          state_d = DIV_END;
      end
      DIV_BY_ZERO: state_d = bus.annul ? DIV_FREE : DIV_END;
      DIV_END:     state_d = DIV_FREE;
      default:     state_d = DIV_FREE;
    endcase
  end

  // Results are loaded only on the transition into DIV_END, so an annulled
  // division leaves hi/lo holding the previous result.
  always_comb begin
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    raw_dvd_d = raw_dvd_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    unique case (state_q)
      DIV_FREE: begin
        if (start == DIV_START) begin
          dvd_d     = (is_signed && bus.ex_reg1[REG_W-1]) ? -bus.ex_reg1 : bus.ex_reg1;
          dvs_d     = (is_signed && bus.ex_reg2[REG_W-1]) ? -bus.ex_reg2 : bus.ex_reg2;
          raw_dvd_d = bus.ex_reg1;
          neg_quo_d = is_signed && (bus.ex_reg1[REG_W-1] ^ bus.ex_reg2[REG_W-1]);
          neg_rem_d = is_signed && bus.ex_reg1[REG_W-1];
          rem_d     = '0;
          cnt_d     = '0;
        end
      end
      DIV_ON: begin
        dvd_d = quo_new;
        rem_d = rem_new;
        cnt_d = cnt_q + 5'd1;
        if (state_d == DIV_END) begin
          lo_d = neg_quo_q ? -quo_new : quo_new;
          hi_d = neg_rem_q ? -rem_new : rem_new;
        end
      end
      DIV_BY_ZERO: begin
        if (state_d == DIV_END) begin
          lo_d = '1;
          hi_d = raw_dvd_q;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    stallreq = 1'b0;
    whilo    = ~DIV_RESULT_READY;
    unique case (state_q)
      DIV_FREE:            stallreq = (start == DIV_START);
      DIV_ON, DIV_BY_ZERO: stallreq = 1'b1;
      DIV_END:             whilo    = DIV_RESULT_READY;
      default: ;
    endcase
  end

  assign bus.stallreq = stallreq;
  assign bus.whilo_o  = whilo;
  assign bus.hi_o     = hi_q;
  assign bus.lo_o     = lo_q;

endmodule

`default_nettype wire
